// File: rtl/spi_frame_rx.sv
// SPI mode-0 receiver for 16-bit {rw, addr[6:0], data[7:0]} frames, MSB first.
// All pads are synchronized into clk; completed frames are reported as one-cycle strobes.
module spi_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       frame_valid,
  output logic       frame_rw,
  output logic [6:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_p, ncs_p;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  state_e      state_q, state_d;
  logic [15:0] shreg_q;
  logic [4:0]  cnt_q;
  logic        frame_valid_q, frame_err_q, frame_rw_q;
  logic [6:0]  frame_addr_q;
  logic [7:0]  frame_data_q;
  logic        frame_ok, frame_bad;

  // Synchronizer chains, then one sampled copy plus its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_s    <= 1'b0;
      copi_s    <= 1'b0;
      ncs_s     <= 1'b0;
      sclk_p    <= 1'b0;
      ncs_p     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_s    <= sclk_sync[SYNC_STAGES-1];
      copi_s    <= copi_sync[SYNC_STAGES-1];
      ncs_s     <= ncs_sync[SYNC_STAGES-1];
      sclk_p    <= sclk_s;
      ncs_p     <= ncs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_p;
  assign ncs_rise  = ncs_s & ~ncs_p;
  assign ncs_fall  = ~ncs_s & ncs_p;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StWaitIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitIdle: if (ncs_s)    state_d = StIdle;
      StIdle:     if (ncs_fall) state_d = StActive;
      StActive:   if (ncs_rise) state_d = StIdle;
      default:                  state_d = StWaitIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StActive);
    frame_ok  = busy && ncs_rise && (cnt_q == 5'd16);
    frame_bad = busy && ncs_rise && (cnt_q != 5'd16);
  end

  // ncs_rise takes priority, so a coincident sclk edge is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q       <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_rw_q    <= 1'b0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
    end else begin
      frame_valid_q <= frame_ok;
      frame_err_q   <= frame_bad;
      if (frame_ok) begin
        frame_rw_q   <= shreg_q[15];
        frame_addr_q <= shreg_q[14:8];
        frame_data_q <= shreg_q[7:0];
      end
      if (state_q == StIdle && ncs_fall) begin
        shreg_q <= '0;
        cnt_q   <= '0;
      end else if (busy && !ncs_rise && sclk_rise && cnt_q != 5'd17) begin
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q < 5'd16) shreg_q <= {shreg_q[14:0], copi_s};
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_rw    = frame_rw_q;
  assign frame_addr  = frame_addr_q;
  assign frame_data  = frame_data_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: pads driven on the falling clk edge, outputs sampled there too.
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, copi, ncs;
  logic       frame_valid, frame_rw, frame_err, busy;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  spi_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .copi        (copi),
    .ncs         (ncs),
    .frame_valid (frame_valid),
    .frame_rw    (frame_rw),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Strobe monitor: running totals plus the fields seen with each frame_valid.
  int          nv = 0;
  int          ne = 0;
  int          nboth = 0;
  logic [15:0] vq[$];

  always @(negedge clk) begin
    if (frame_valid) begin
      nv = nv + 1;
      vq.push_back({frame_rw, frame_addr, frame_data});
    end
    if (frame_err) ne = ne + 1;
    if (frame_valid && frame_err) nboth = nboth + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    copi = b;
    cyc(4);
    sclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
  endtask

  // Drops ncs, shifts n bits of pat MSB first, leaves ncs low.
  task automatic body(input logic [31:0] pat, input int n);
    ncs = 1'b0;
    cyc(6);
    for (int i = 0; i < n; i++) spi_bit(pat[n-1-i]);
    cyc(4);
  endtask

  int v0, e0, lat;

  initial begin
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    cyc(3);
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fields", {16'd0, frame_rw, frame_addr, frame_data}, 32'd0);
    rst = 1'b0;
    cyc(8);

    // Write frame 0x8480 with latency measurement
    v0 = nv; e0 = ne;
    body(32'h8480, 16);
    check("wr_busy_active", {31'd0, busy}, 32'd1);
    ncs = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (frame_valid && lat == 0) lat = k;
    end
    cyc(2);
    check("wr_latency", lat, 32'd4);
    check("wr_nvalid", nv - v0, 32'd1);
    check("wr_nerr", ne - e0, 32'd0);
    if (nv > v0) check("wr_strobe_fields", {16'd0, vq[v0]}, 32'h8480);
    check("wr_fields", {16'd0, frame_rw, frame_addr, frame_data}, 32'h8480);
    check("wr_busy_after", {31'd0, busy}, 32'd0);

    // Short frame: 12 bits
    v0 = nv; e0 = ne;
    body(32'hFFF, 12);
    ncs = 1'b1;
    cyc(12);
    check("short_nerr", ne - e0, 32'd1);
    check("short_nvalid", nv - v0, 32'd0);
    check("short_fields", {16'd0, frame_rw, frame_addr, frame_data}, 32'h8480);

    // Long frame: 0xA5C3 plus 4 extra bits
    v0 = nv; e0 = ne;
    body({12'd0, 16'hA5C3, 4'hA}, 20);
    ncs = 1'b1;
    cyc(12);
    check("long_nerr", ne - e0, 32'd1);
    check("long_nvalid", nv - v0, 32'd0);
    check("long_fields", {16'd0, frame_rw, frame_addr, frame_data}, 32'h8480);

    // Back-to-back with a 2-cycle ncs-high gap
    v0 = nv; e0 = ne;
    body(32'h0011, 16);
    ncs = 1'b1;
    cyc(2);
    body(32'h82FF, 16);
    ncs = 1'b1;
    cyc(12);
    check("b2b_nvalid", nv - v0, 32'd2);
    check("b2b_nerr", ne - e0, 32'd0);
    if (nv > v0) check("b2b_first", {16'd0, vq[v0]}, 32'h0011);
    if (nv > v0 + 1) check("b2b_second", {16'd0, vq[v0+1]}, 32'h82FF);

    // Reset mid-frame, then ncs held low (with sclk activity) after reset
    v0 = nv; e0 = ne;
    ncs = 1'b0;
    cyc(6);
    for (int i = 0; i < 8; i++) spi_bit(i[0]);
    rst = 1'b1;
    cyc(2);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_fields", {16'd0, frame_rw, frame_addr, frame_data}, 32'd0);
    rst = 1'b0;
    cyc(10);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    check("mrst_low_busy", {31'd0, busy}, 32'd0);
    check("mrst_no_strobe", (nv - v0) + (ne - e0), 32'd0);
    ncs = 1'b1;
    cyc(4);
    body(32'h8101, 16);
    ncs = 1'b1;
    cyc(12);
    check("post_rst_nvalid", nv - v0, 32'd1);
    check("post_rst_nerr", ne - e0, 32'd0);
    if (nv > v0) check("post_rst_fields", {16'd0, vq[v0]}, 32'h8101);

    // sclk rise coincident with ncs rise after 16 bits
    v0 = nv; e0 = ne;
    body(32'h5A3C, 16);
    copi = 1'b1;
    cyc(1);
    sclk = 1'b1;
    ncs  = 1'b1;
    cyc(4);
    sclk = 1'b0;
    cyc(12);
    check("coinc_nvalid", nv - v0, 32'd1);
    check("coinc_nerr", ne - e0, 32'd0);
    check("coinc_fields", {16'd0, frame_rw, frame_addr, frame_data}, 32'h5A3C);

    check("never_both", nboth, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
